// File: rtl/axi_rr_arbiter.sv
// Two-master to one-slave AXI4-lite arbiter, round-robin on ties, one
// transaction in flight at a time (read preferred within the granted master).
module axi_rr_arbiter #(
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  // upstream masters, {m1,m0} packed
  input  logic [63:0] m_araddr,
  input  logic [1:0]  m_arvalid,
  output logic [1:0]  m_arready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic [1:0]  m_rvalid,
  input  logic [1:0]  m_rready,
  input  logic [63:0] m_awaddr,
  input  logic [1:0]  m_awvalid,
  output logic [1:0]  m_awready,
  input  logic [63:0] m_wdata,
  input  logic [7:0]  m_wstrb,
  input  logic [1:0]  m_wvalid,
  output logic [1:0]  m_wready,
  output logic [1:0]  m_bresp,
  output logic [1:0]  m_bvalid,
  input  logic [1:0]  m_bready,
  // downstream slave
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } state_t;

  state_t      state;
  logic        grant;
  logic        last_served;
  logic        aw_done;
  logic        w_done;

  logic [1:0]  req;
  logic        pick;
  logic [1:0]  gsel;
  logic        live;
  logic        aw_fire;
  logic        w_fire;

  logic [AW-1:0] g_araddr;
  logic [AW-1:0] g_awaddr;
  logic [DW-1:0] g_wdata;
  logic [SW-1:0] g_wstrb;
  logic          g_arvalid;
  logic          g_awvalid;
  logic          g_wvalid;
  logic          g_rready;
  logic          g_bready;

  // Arbitration: a lone requester wins, a tie goes away from the last served.
  always_comb begin
    req  = m_arvalid | m_awvalid;
    pick = (req == 2'b11) ? ~last_served : req[1];
  end

  // Select the granted master's request-side signals.
  always_comb begin
    g_araddr  = grant ? m_araddr[63:32] : m_araddr[31:0];
    g_awaddr  = grant ? m_awaddr[63:32] : m_awaddr[31:0];
    g_wdata   = grant ? m_wdata[63:32]  : m_wdata[31:0];
    g_wstrb   = grant ? m_wstrb[7:4]    : m_wstrb[3:0];
    g_arvalid = m_arvalid[grant];
    g_awvalid = m_awvalid[grant];
    g_wvalid  = m_wvalid[grant];
    g_rready  = m_rready[grant];
    g_bready  = m_bready[grant];
    gsel      = grant ? 2'b10 : 2'b01;
    live      = ~reset;
  end

  always_comb begin
    aw_fire = s_awvalid & s_awready;
    w_fire  = s_wvalid & s_wready;
  end

  // Transaction sequencer; no new grant until the response handshake ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= FIRST_PRIO;
      last_served <= ~FIRST_PRIO;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick;
            state <= m_arvalid[pick] ? RADDR : WADDR;
          end
        end
        RADDR: begin
          if (s_arvalid & s_arready) state <= RDATA;
        end
        RDATA: begin
          if (s_rvalid & s_rready) begin
            state       <= IDLE;
            last_served <= grant;
          end
        end
        WADDR: begin
          if ((aw_done | aw_fire) & (w_done | w_fire)) begin
            state   <= WRESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
          end
        end
        WRESP: begin
          if (s_bvalid & s_bready) begin
            state       <= IDLE;
            last_served <= grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel routing: payloads pass straight through, only handshakes are gated.
  always_comb begin
    s_araddr  = g_araddr;
    s_awaddr  = g_awaddr;
    s_wdata   = g_wdata;
    s_wstrb   = g_wstrb;
    m_rdata   = s_rdata;
    m_rresp   = s_rresp;
    m_bresp   = s_bresp;

    s_arvalid = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_rready  = 1'b0;
    s_bready  = 1'b0;
    m_arready = 2'b00;
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_rvalid  = 2'b00;
    m_bvalid  = 2'b00;

    case (state)
      RADDR: begin
        s_arvalid = live & g_arvalid;
        m_arready = gsel & {2{live & s_arready}};
      end
      RDATA: begin
        s_rready = live & g_rready;
        m_rvalid = gsel & {2{live & s_rvalid}};
      end
      WADDR: begin
        s_awvalid = live & g_awvalid & ~aw_done;
        s_wvalid  = live & g_wvalid & ~w_done;
        m_awready = gsel & {2{live & s_awready & ~aw_done}};
        m_wready  = gsel & {2{live & s_wready & ~w_done}};
      end
      WRESP: begin
        s_bready = live & g_bready;
        m_bvalid = gsel & {2{live & s_bvalid}};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_axi_rr_arbiter;

  localparam logic FIRST = 1'b0;

  logic        clock;
  logic        reset;
  logic [63:0] m_araddr;
  logic [1:0]  m_arvalid;
  logic [1:0]  m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic [1:0]  m_rvalid;
  logic [1:0]  m_rready;
  logic [63:0] m_awaddr;
  logic [1:0]  m_awvalid;
  logic [1:0]  m_awready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_wvalid;
  logic [1:0]  m_wready;
  logic [1:0]  m_bresp;
  logic [1:0]  m_bvalid;
  logic [1:0]  m_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;

  int n_vec = 0;
  int n_bad = 0;

  axi_rr_arbiter #(.FIRST_PRIO(FIRST)) dut (
    .clock(clock), .reset(reset),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by who owns it,
  // whether it is a read, and which of its handshakes are already done.
  logic m_busy = 1'b0;
  logic m_own = 1'b0;
  logic m_rd = 1'b0;
  logic m_addr_done = 1'b0;
  logic m_aw_d = 1'b0;
  logic m_w_d = 1'b0;
  logic m_wresp = 1'b0;
  logic m_last = ~FIRST;

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0;
      m_last = ~FIRST;
    end else if (!m_busy) begin
      if ((m_arvalid | m_awvalid) != 2'b00) begin
        if ((m_arvalid | m_awvalid) == 2'b11) m_own = ~m_last;
        else m_own = m_arvalid[1] | m_awvalid[1];
        m_rd = m_arvalid[m_own];
        m_busy = 1'b1;
        m_addr_done = 1'b0;
        m_aw_d = 1'b0;
        m_w_d = 1'b0;
        m_wresp = 1'b0;
      end
    end else if (m_rd) begin
      if (!m_addr_done) begin
        if (m_arvalid[m_own] && s_arready) m_addr_done = 1'b1;
      end else if (s_rvalid && m_rready[m_own]) begin
        m_busy = 1'b0;
        m_last = m_own;
      end
    end else if (!m_wresp) begin
      if (m_awvalid[m_own] && s_awready) m_aw_d = 1'b1;
      if (m_wvalid[m_own] && s_wready) m_w_d = 1'b1;
      if (m_aw_d && m_w_d) m_wresp = 1'b1;
    end else if (s_bvalid && m_bready[m_own]) begin
      m_busy = 1'b0;
      m_last = m_own;
    end
  end

  // Compare process: expected outputs derived from the model, mid-cycle.
  always @(negedge clock) begin
    logic [1:0] osel;
    logic e_sar, e_saw, e_sw, e_srr, e_sbr;
    logic [1:0] e_mar, e_maw, e_mw, e_mrv, e_mbv;
    osel = m_own ? 2'b10 : 2'b01;
    e_sar = 0; e_saw = 0; e_sw = 0; e_srr = 0; e_sbr = 0;
    e_mar = 0; e_maw = 0; e_mw = 0; e_mrv = 0; e_mbv = 0;
    if (!reset && m_busy) begin
      if (m_rd && !m_addr_done) begin
        e_sar = m_arvalid[m_own];
        e_mar = s_arready ? osel : 2'b00;
      end else if (m_rd) begin
        e_srr = m_rready[m_own];
        e_mrv = s_rvalid ? osel : 2'b00;
      end else if (!m_wresp) begin
        e_saw = m_awvalid[m_own] & ~m_aw_d;
        e_sw  = m_wvalid[m_own] & ~m_w_d;
        e_maw = (s_awready && !m_aw_d) ? osel : 2'b00;
        e_mw  = (s_wready && !m_w_d) ? osel : 2'b00;
      end else begin
        e_sbr = m_bready[m_own];
        e_mbv = s_bvalid ? osel : 2'b00;
      end
    end
    chk("s_arvalid", 64'(s_arvalid), 64'(e_sar));
    chk("s_awvalid", 64'(s_awvalid), 64'(e_saw));
    chk("s_wvalid",  64'(s_wvalid),  64'(e_sw));
    chk("s_rready",  64'(s_rready),  64'(e_srr));
    chk("s_bready",  64'(s_bready),  64'(e_sbr));
    chk("m_arready", 64'(m_arready), 64'(e_mar));
    chk("m_awready", 64'(m_awready), 64'(e_maw));
    chk("m_wready",  64'(m_wready),  64'(e_mw));
    chk("m_rvalid",  64'(m_rvalid),  64'(e_mrv));
    chk("m_bvalid",  64'(m_bvalid),  64'(e_mbv));
    chk("m_rdata",   64'(m_rdata),   64'(s_rdata));
    chk("m_rresp",   64'(m_rresp),   64'(s_rresp));
    chk("m_bresp",   64'(m_bresp),   64'(s_bresp));
    if (e_sar) chk("s_araddr", 64'(s_araddr), m_own ? 64'(m_araddr[63:32]) : 64'(m_araddr[31:0]));
    if (e_saw) chk("s_awaddr", 64'(s_awaddr), m_own ? 64'(m_awaddr[63:32]) : 64'(m_awaddr[31:0]));
    if (e_sw) begin
      chk("s_wdata", 64'(s_wdata), m_own ? 64'(m_wdata[63:32]) : 64'(m_wdata[31:0]));
      chk("s_wstrb", 64'(s_wstrb), m_own ? 64'(m_wstrb[7:4]) : 64'(m_wstrb[3:0]));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m_araddr = '0; m_arvalid = '0; m_rready = 2'b11;
    m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0;
    m_bready = 2'b11;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
    do_reset();
    settle();
    chk("reset_quiet", {54'd0, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
        m_arready, m_rvalid, m_bvalid}, 64'd0);

    // Lone m0 read
    m_araddr[31:0] = 32'h3000_0000;
    m_arvalid = 2'b01;
    cyc();
    settle();
    chk("rd0_arvalid", 64'(s_arvalid), 64'd1);
    chk("rd0_araddr", 64'(s_araddr), 64'h3000_0000);
    s_arready = 1;
    cyc();
    m_arvalid = 2'b00; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
    settle();
    chk("rd0_rvalid", 64'(m_rvalid), 64'h1);
    chk("rd0_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    cyc();
    s_rvalid = 0;

    // Tied reads alternate 0,1,0,1 after reset
    do_reset();
    m_araddr = {32'h2000_0000, 32'h1000_0000};
    m_arvalid = 2'b11;
    s_arready = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      settle();
      chk("tie_araddr", 64'(s_araddr), (k % 2 == 0) ? 64'h1000_0000 : 64'h2000_0000);
      cyc();
      s_rvalid = 1;
      settle();
      chk("tie_rvalid", 64'(m_rvalid), (k % 2 == 0) ? 64'h1 : 64'h2);
      cyc();
      s_rvalid = 0;
    end
    m_arvalid = 2'b00; s_arready = 0;
    cyc();

    // m1 write: aw accepted first cycle, w two cycles later
    m_awaddr[63:32] = 32'h4000_0010;
    m_wdata[63:32] = 32'hCAFE_F00D;
    m_wstrb[7:4] = 4'hF;
    m_awvalid = 2'b10; m_wvalid = 2'b10;
    cyc();
    s_awready = 1;
    settle();
    chk("wr1_awvalid_t1", 64'(s_awvalid), 64'd1);
    chk("wr1_awaddr", 64'(s_awaddr), 64'h4000_0010);
    cyc();
    s_awready = 0;
    settle();
    chk("wr1_awvalid_t2", 64'(s_awvalid), 64'd0);
    chk("wr1_wvalid_t2", 64'(s_wvalid), 64'd1);
    cyc();
    s_wready = 1;
    settle();
    chk("wr1_wready_t3", 64'(m_wready), 64'h2);
    chk("wr1_bready_t3", 64'(s_bready), 64'd0);
    cyc();
    s_wready = 0; m_awvalid = 2'b00; m_wvalid = 2'b00;
    s_bvalid = 1; s_bresp = 2'b00;
    settle();
    chk("wr1_bvalid", 64'(m_bvalid), 64'h2);
    chk("wr1_bresp", 64'(m_bresp), 64'h0);
    chk("wr1_bready", 64'(s_bready), 64'd1);
    cyc();
    s_bvalid = 0;

    // m1 read and write together: read first, then write in a later IDLE
    m_araddr[63:32] = 32'h5000_0000;
    m_arvalid = 2'b10; m_awvalid = 2'b10; m_wvalid = 2'b10;
    s_arready = 1; s_awready = 1; s_wready = 1;
    cyc();
    settle();
    chk("rw1_arvalid", 64'(s_arvalid), 64'd1);
    chk("rw1_awvalid_during_rd", 64'(s_awvalid), 64'd0);
    cyc();
    m_arvalid = 2'b00;
    s_rvalid = 1;
    cyc();
    s_rvalid = 0;
    cyc();
    settle();
    chk("rw1_aw_w_together", {62'd0, s_awvalid, s_wvalid}, 64'h3);
    cyc();
    m_awvalid = 2'b00; m_wvalid = 2'b00;
    s_bvalid = 1;
    settle();
    chk("rw1_bvalid", 64'(m_bvalid), 64'h2);
    cyc();
    s_bvalid = 0; s_arready = 0; s_awready = 0; s_wready = 0;

    // Stray read/write responses during WADDR are ignored
    m_awaddr[31:0] = 32'h6000_0004; m_wdata[31:0] = 32'h1234_5678; m_wstrb[3:0] = 4'h3;
    m_awvalid = 2'b01; m_wvalid = 2'b01;
    cyc();
    s_rvalid = 1; s_bvalid = 1;
    settle();
    chk("stray_rready", 64'(s_rready), 64'd0);
    chk("stray_rvalid", 64'(m_rvalid), 64'd0);
    chk("stray_bvalid", 64'(m_bvalid), 64'd0);
    cyc();
    s_rvalid = 0; s_bvalid = 0; s_awready = 1; s_wready = 1;
    cyc();
    s_awready = 0; s_wready = 0; m_awvalid = 2'b00; m_wvalid = 2'b00;
    s_bvalid = 1;
    cyc();
    s_bvalid = 0;

    // Reset in RDATA, then a fresh m1 request
    m_arvalid = 2'b01; s_arready = 1;
    cyc();
    cyc();
    m_arvalid = 2'b00;
    settle();
    chk("rst_rd_rready_before", 64'(s_rready), 64'd1);
    reset = 1'b1;
    s_rvalid = 1;
    cyc();
    reset = 1'b0;
    settle();
    chk("rst_rd_quiet", {54'd0, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
        m_arready, m_rvalid, m_bvalid}, 64'd0);
    s_rvalid = 0;
    m_arvalid = 2'b10;
    cyc();
    settle();
    chk("rst_m1_arready", 64'(m_arready), 64'h2);
    chk("rst_m1_araddr", 64'(s_araddr), 64'h5000_0000);
    cyc();
    m_arvalid = 2'b00; s_arready = 0;
    s_rvalid = 1;
    cyc();
    s_rvalid = 0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
